// File: rtl/fp16_addsub_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp16_addsub_sequencer_pkg
// Description : Shared constants for the binary16 add/subtract sequencer:
//               field widths, special encodings and FSM state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package fp16_addsub_sequencer_pkg;

    localparam int c_exp_w = 5;
    localparam int c_man_w = 10;

    localparam logic [15:0] c_fp16_qnan = 16'h7E00;
    // Magnitude only; the sign is prepended where it is used.
    localparam logic [14:0] c_fp16_inf  = 15'h7C00;

    localparam int c_st_w = 3;
    localparam logic [c_st_w-1:0] c_st_idle  = 3'd0;
    localparam logic [c_st_w-1:0] c_st_order = 3'd1;
    localparam logic [c_st_w-1:0] c_st_align = 3'd2;
    localparam logic [c_st_w-1:0] c_st_add   = 3'd3;
    localparam logic [c_st_w-1:0] c_st_norm  = 3'd4;
    localparam logic [c_st_w-1:0] c_st_pack  = 3'd5;
    localparam logic [c_st_w-1:0] c_st_done  = 3'd6;

endpackage
`default_nettype wire

// File: rtl/fp16_addsub_sequencer_classify.sv
`default_nettype none
// ============================================================================
// Module      : fp16_classify
// Description : Combinational classifier for one binary16 magnitude.
//               Denormals (exp==0) are reported as zero.
// Ports       : i_mag     - exponent and fraction fields (sign excluded)
//               o_is_nan  - exp all ones, fraction non-zero
//               o_is_inf  - exp all ones, fraction zero
//               o_is_zero - exp zero (zero or flushed denormal)
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_classify
    import fp16_addsub_sequencer_pkg::*;
(
    input  logic [c_exp_w+c_man_w-1:0] i_mag,
    output logic                       o_is_nan,
    output logic                       o_is_inf,
    output logic                       o_is_zero
);

    logic [c_exp_w-1:0] w_exp;
    logic [c_man_w-1:0] w_frac;

    assign w_exp     = i_mag[c_exp_w+c_man_w-1:c_man_w];
    assign w_frac    = i_mag[c_man_w-1:0];
    assign o_is_nan  = (&w_exp) && (|w_frac);
    assign o_is_inf  = (&w_exp) && !(|w_frac);
    assign o_is_zero = !(|w_exp);

endmodule
`default_nettype wire

// File: rtl/fp16_addsub_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fp16_addsub_sequencer
// Description : Multi-cycle binary16 add/subtract. One operation at a time;
//               alignment and normalization shift one bit per cycle.
//               Truncating rounding, denormals flushed to zero.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               in_valid/in_ready      - operand handshake (ready only in IDLE)
//               a, b, sub              - operands; sub=1 computes a-b
//               res_valid/res_ready    - result handshake
//               result                 - binary16 result, stable while valid
//               ovf, unf, inv          - overflow / underflow / invalid flags
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_addsub_sequencer
    import fp16_addsub_sequencer_pkg::*;
#(
    parameter int EXP_W       = c_exp_w,
    parameter int MAN_W       = c_man_w,
    parameter int ALIGN_LIMIT = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   sub,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   ovf,
    output logic                   unf,
    output logic                   inv
);

    localparam logic [EXP_W-1:0] c_align_limit = EXP_W'(ALIGN_LIMIT);

    logic [c_st_w-1:0]       r_state;
    logic [EXP_W+MAN_W:0]    r_a;
    logic [EXP_W+MAN_W:0]    r_b;
    logic [EXP_W+MAN_W:0]    r_result;
    // r_ml doubles as the 12-bit sum from ADD onward.
    logic [MAN_W+1:0]        r_ml;
    logic [MAN_W+1:0]        r_ms;
    logic [EXP_W-1:0]        r_exp;
    logic [EXP_W-1:0]        r_cnt;
    logic                    r_sign;
    logic                    r_sl;
    logic                    r_ss;
    logic                    r_ovf;
    logic                    r_unf;
    logic                    r_inv;
    logic                    r_in_ready;
    logic                    r_res_valid;

    logic                    w_a_nan, w_a_inf, w_a_zero;
    logic                    w_b_nan, w_b_inf, w_b_zero;
    logic                    w_sa, w_sb, w_a_is_l;
    logic [EXP_W-1:0]        w_ea, w_eb, w_diff;
    logic [MAN_W+1:0]        w_ma, w_mb;

    fp16_classify u_class_a (
        .i_mag     (r_a[EXP_W+MAN_W-1:0]),
        .o_is_nan  (w_a_nan),
        .o_is_inf  (w_a_inf),
        .o_is_zero (w_a_zero)
    );

    fp16_classify u_class_b (
        .i_mag     (r_b[EXP_W+MAN_W-1:0]),
        .o_is_nan  (w_b_nan),
        .o_is_inf  (w_b_inf),
        .o_is_zero (w_b_zero)
    );

    assign w_sa = r_a[EXP_W+MAN_W];
    assign w_sb = r_b[EXP_W+MAN_W];
    assign w_ea = r_a[EXP_W+MAN_W-1:MAN_W];
    assign w_eb = r_b[EXP_W+MAN_W-1:MAN_W];
    // Zeros (and flushed denormals) contribute a fully-zero mantissa.
    assign w_ma = w_a_zero ? '0 : {2'b01, r_a[MAN_W-1:0]};
    assign w_mb = w_b_zero ? '0 : {2'b01, r_b[MAN_W-1:0]};
    // Ties go to A so the exponent difference is never negative.
    assign w_a_is_l = (w_ea >= w_eb);
    assign w_diff   = w_a_is_l ? (w_ea - w_eb) : (w_eb - w_ea);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_ml        <= '0;
            r_ms        <= '0;
            r_exp       <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_sl        <= 1'b0;
            r_ss        <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_inv       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= b ^ {sub, {(EXP_W+MAN_W){1'b0}}};
                        r_ovf      <= 1'b0;
                        r_unf      <= 1'b0;
                        r_inv      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= c_st_order;
                    end
                end
                c_st_order: begin
                    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
                        r_result    <= c_fp16_qnan;
                        r_inv       <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_state     <= c_st_done;
                    end else if (w_a_inf) begin
                        r_result    <= r_a;
                        r_res_valid <= 1'b1;
                        r_state     <= c_st_done;
                    end else if (w_b_inf) begin
                        r_result    <= r_b;
                        r_res_valid <= 1'b1;
                        r_state     <= c_st_done;
                    end else begin
                        r_ml  <= w_a_is_l ? w_ma : w_mb;
                        r_sl  <= w_a_is_l ? w_sa : w_sb;
                        r_ss  <= w_a_is_l ? w_sb : w_sa;
                        r_exp <= w_a_is_l ? w_ea : w_eb;
                        r_cnt <= w_diff;
                        if (w_diff >= c_align_limit) begin
                            // S would shift out entirely; skip the alignment walk.
                            r_ms    <= '0;
                            r_state <= c_st_add;
                        end else begin
                            r_ms    <= w_a_is_l ? w_mb : w_ma;
                            r_state <= (w_diff == '0) ? c_st_add : c_st_align;
                        end
                    end
                end
                c_st_align: begin
                    r_ms  <= r_ms >> 1;
                    r_cnt <= r_cnt - EXP_W'(1);
                    // Leave as the last shift is performed.
                    if (r_cnt == EXP_W'(1)) begin
                        r_state <= c_st_add;
                    end
                end
                c_st_add: begin
                    if (r_sl == r_ss) begin
                        r_ml   <= r_ml + r_ms;
                        r_sign <= r_sl;
                    end else if (r_ml >= r_ms) begin
                        r_ml   <= r_ml - r_ms;
                        r_sign <= r_sl;
                    end else begin
                        r_ml   <= r_ms - r_ml;
                        r_sign <= r_ss;
                    end
                    r_state <= c_st_norm;
                end
                c_st_norm: begin
                    if (r_ml == '0) begin
                        // Exact cancellation always yields +0.
                        r_sign  <= 1'b0;
                        r_exp   <= '0;
                        r_state <= c_st_pack;
                    end else if (r_ml[MAN_W+1]) begin
                        r_ml  <= r_ml >> 1;
                        r_exp <= r_exp + EXP_W'(1);
                    end else if (r_ml[MAN_W]) begin
                        r_state <= c_st_pack;
                    end else if (r_exp > EXP_W'(1)) begin
                        r_ml  <= r_ml << 1;
                        r_exp <= r_exp - EXP_W'(1);
                    end else begin
                        // Would need a denormal: flush to +0.
                        r_unf   <= 1'b1;
                        r_ml    <= '0;
                        r_sign  <= 1'b0;
                        r_exp   <= '0;
                        r_state <= c_st_pack;
                    end
                end
                c_st_pack: begin
                    if (&r_exp) begin
                        r_result <= {r_sign, c_fp16_inf};
                        r_ovf    <= 1'b1;
                    end else begin
                        r_result <= {r_sign, r_exp, r_ml[MAN_W-1:0]};
                    end
                    r_res_valid <= 1'b1;
                    r_state     <= c_st_done;
                end
                c_st_done: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_st_idle;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= c_st_idle;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign res_valid = r_res_valid;
    assign result    = r_result;
    assign ovf       = r_ovf;
    assign unf       = r_unf;
    assign inv       = r_inv;

endmodule
`default_nettype wire

// File: tb/tb_fp16_addsub_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_addsub_sequencer
// Description : Directed self-checking bench for fp16_addsub_sequencer.
//               Expected results and latencies are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_addsub_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        sub = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] result;
    logic        ovf, unf, inv;

    int n_total = 0;
    int n_pass  = 0;

    fp16_addsub_sequencer #(
        .EXP_W       (5),
        .MAN_W       (10),
        .ALIGN_LIMIT (12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf),
        .inv       (inv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one operation and wait for res_valid; does not retire it.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tsub, input logic [15:0] er, input logic eo,
                          input logic eu, input logic ei, input int elat);
        int n;
        a = ta; b = tb; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!res_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_valid"},  32'(res_valid), 32'(1));
        check({tag, "_lat"},    32'(n),         32'(elat));
        check({tag, "_result"}, 32'(result),    32'(er));
        check({tag, "_flags"},  32'({ovf, unf, inv}), 32'({eo, eu, ei}));
        check({tag, "_busy"},   32'(in_ready),  32'(0));
    endtask

    task automatic retire(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, "_ret_valid"}, 32'(res_valid), 32'(0));
        check({tag, "_ret_ready"}, 32'(in_ready),  32'(1));
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_in_ready",  32'(in_ready),  32'(1));
        check("reset_res_valid", 32'(res_valid), 32'(0));
        check("reset_result",    32'(result),    32'(0));
        check("reset_flags",     32'({ovf, unf, inv}), 32'(0));

        // 1.0 + 2.0 = 3.0, one alignment shift
        run_op("add_1_2", 16'h3C00, 16'h4000, 1'b0, 16'h4200, 0, 0, 0, 6);
        retire("add_1_2");
        // 1024 + 1, ten alignment shifts
        run_op("add_diff10", 16'h6400, 16'h3C00, 1'b0, 16'h6401, 0, 0, 0, 15);
        retire("add_diff10");
        // exact cancellation
        run_op("sub_cancel", 16'h3C00, 16'h3C00, 1'b1, 16'h0000, 0, 0, 0, 5);
        retire("sub_cancel");
        // max normal doubled overflows
        run_op("ovf", 16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1, 0, 0, 6);
        retire("ovf");
        // denormal B is flushed
        run_op("denorm_b", 16'h0400, 16'h03FF, 1'b1, 16'h0400, 0, 0, 0, 6);
        retire("denorm_b");
        // 1.0 - 0.5 needs one left shift
        run_op("norm_left", 16'h3C00, 16'h3800, 1'b1, 16'h3800, 0, 0, 0, 7);
        retire("norm_left");
        // 1.0 - 2.0 = -1.0
        run_op("neg_res", 16'h3C00, 16'h4000, 1'b1, 16'hBC00, 0, 0, 0, 7);
        retire("neg_res");
        // result below min normal is flushed with unf
        run_op("unf", 16'h0401, 16'h0400, 1'b1, 16'h0000, 0, 1, 0, 5);
        retire("unf");
        // diff 11: full walk, S shifts to zero
        run_op("diff11", 16'h6800, 16'h3C00, 1'b0, 16'h6800, 0, 0, 0, 16);
        retire("diff11");
        // diff 12: early-out, no align cycles
        run_op("diff12", 16'h6C00, 16'h3C00, 1'b0, 16'h6C00, 0, 0, 0, 5);
        retire("diff12");
        // specials
        run_op("inf_m_inf", 16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 0, 0, 1, 2);
        retire("inf_m_inf");
        run_op("nan_in", 16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 0, 0, 1, 2);
        retire("nan_in");
        run_op("neg_inf", 16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 0, 0, 0, 2);
        retire("neg_inf");
        run_op("inf_sub_inf", 16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 0, 0, 1, 2);
        retire("inf_sub_inf");

        // back-pressure: result held, new operands ignored
        run_op("hold", 16'h3C00, 16'h4000, 1'b0, 16'h4200, 0, 0, 0, 6);
        a = 16'h7E01; b = 16'h1234; sub = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            check("hold_result", 32'(result),    32'(16'h4200));
            check("hold_flags",  32'({ovf, unf, inv}), 32'(0));
            check("hold_valid",  32'(res_valid), 32'(1));
            check("hold_ready",  32'(in_ready),  32'(0));
        end
        in_valid = 1'b0;
        retire("hold");
        run_op("after_hold", 16'h4000, 16'h3C00, 1'b0, 16'h4200, 0, 0, 0, 6);
        retire("after_hold");

        // reset in the middle of ALIGN aborts the op
        a = 16'h6400; b = 16'h3C00; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_ready", 32'(in_ready),  32'(1));
        check("mid_rst_valid", 32'(res_valid), 32'(0));
        repeat (20) @(posedge clk);
        #1;
        check("mid_rst_quiet", 32'(res_valid), 32'(0));
        run_op("post_rst", 16'h3C00, 16'h4000, 1'b0, 16'h4200, 0, 0, 0, 6);
        retire("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
